ov7670_cfg_ctrl: RTL and testbench

- Sequences the OV7670 power-up register configuration through the single-register SCCB write master.
- After reset it waits out the sensor power-up time. It then walks a fixed table of (register address, data) pairs and issues one SCCB write per entry.
- Each write waits for the master's completion pulse, with a timeout and retry per entry.
- Reports busy/done/error status to the camera top level. A `start` pulse re-runs the whole table without repeating the power-up wait.

---
 rtl/ov7670_cfg_pkg.sv | 31 +++
 rtl/ov7670_cfg_rom.sv | 95 +++++++++
 rtl/ov7670_cfg_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ov7670_cfg_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 power-up configuration sequencer.
//   cfg_state_e : sequencer state encoding
//   cfg_entry_t : one table entry, {register address, register data}
//   DELAY_MARK  : table address that means "wait" instead of "write"
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_LOAD  = 3'd1,
        ST_REQ   = 3'd2,
        ST_DELAY = 3'd3,
        ST_GAP   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } cfg_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam logic [7:0] DELAY_MARK = 8'hFF;

    // Length of the stock RGB565/VGA table held in ov7670_cfg_rom.
    localparam int unsigned OV7670_REG_NUM = 76;

    function automatic logic is_delay_mark(input cfg_entry_t e);
        return e.addr == DELAY_MARK;
    endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Combinational OV7670 register table: COM7 soft reset, a settle delay,
// then the RGB565 / VGA / gamma / AEC settings.
//   idx   : entry index (0..75 populated)
//   entry : {addr, data}; addr 8'hFF marks a delay entry
module ov7670_cfg_rom
    import ov7670_cfg_pkg::*;
(
    input  logic [7:0] idx,
    output cfg_entry_t entry
);

    always_comb begin
        entry = {DELAY_MARK, 8'h00};
        case (idx)
            8'd0:  entry = {8'h12, 8'h80};   // COM7 soft reset
            8'd1:  entry = {DELAY_MARK, 8'h00};
            8'd2:  entry = {8'h12, 8'h04};   // COM7 RGB output, VGA
            8'd3:  entry = {8'h11, 8'h80};   // CLKRC
            8'd4:  entry = {8'h0C, 8'h00};   // COM3
            8'd5:  entry = {8'h3E, 8'h00};   // COM14
            8'd6:  entry = {8'h04, 8'h00};   // COM1
            8'd7:  entry = {8'h40, 8'hD0};   // COM15 RGB565 full range
            8'd8:  entry = {8'h3A, 8'h04};   // TSLB
            8'd9:  entry = {8'h14, 8'h18};   // COM9 AGC ceiling
            8'd10: entry = {8'h4F, 8'hB3};   // colour matrix
            8'd11: entry = {8'h50, 8'hB3};
            8'd12: entry = {8'h51, 8'h00};
            8'd13: entry = {8'h52, 8'h3D};
            8'd14: entry = {8'h53, 8'hA7};
            8'd15: entry = {8'h54, 8'hE4};
            8'd16: entry = {8'h58, 8'h9E};
            8'd17: entry = {8'h3D, 8'hC0};   // COM13
            8'd18: entry = {8'h17, 8'h14};   // HSTART
            8'd19: entry = {8'h18, 8'h02};   // HSTOP
            8'd20: entry = {8'h32, 8'h80};   // HREF
            8'd21: entry = {8'h19, 8'h03};   // VSTART
            8'd22: entry = {8'h1A, 8'h7B};   // VSTOP
            8'd23: entry = {8'h03, 8'h0A};   // VREF
            8'd24: entry = {8'h0F, 8'h41};   // COM6
            8'd25: entry = {8'h1E, 8'h00};   // MVFP
            8'd26: entry = {8'h33, 8'h0B};   // CHLF
            8'd27: entry = {8'h3C, 8'h78};   // COM12
            8'd28: entry = {8'h69, 8'h00};   // GFIX
            8'd29: entry = {8'h74, 8'h00};
            8'd30: entry = {8'hB0, 8'h84};
            8'd31: entry = {8'hB1, 8'h0C};   // ABLC1
            8'd32: entry = {8'hB2, 8'h0E};
            8'd33: entry = {8'hB3, 8'h80};   // THL_ST
            8'd34: entry = {8'h70, 8'h3A};   // scaling
            8'd35: entry = {8'h71, 8'h35};
            8'd36: entry = {8'h72, 8'h11};
            8'd37: entry = {8'h73, 8'hF0};
            8'd38: entry = {8'hA2, 8'h02};
            8'd39: entry = {8'h7A, 8'h20};   // gamma curve
            8'd40: entry = {8'h7B, 8'h10};
            8'd41: entry = {8'h7C, 8'h1E};
            8'd42: entry = {8'h7D, 8'h35};
            8'd43: entry = {8'h7E, 8'h5A};
            8'd44: entry = {8'h7F, 8'h69};
            8'd45: entry = {8'h80, 8'h76};
            8'd46: entry = {8'h81, 8'h80};
            8'd47: entry = {8'h82, 8'h88};
            8'd48: entry = {8'h83, 8'h8F};
            8'd49: entry = {8'h84, 8'h96};
            8'd50: entry = {8'h85, 8'hA3};
            8'd51: entry = {8'h86, 8'hAF};
            8'd52: entry = {8'h87, 8'hC4};
            8'd53: entry = {8'h88, 8'hD7};
            8'd54: entry = {8'h89, 8'hE8};
            8'd55: entry = {8'h13, 8'hE0};   // COM8, AGC/AEC off while seeding
            8'd56: entry = {8'h00, 8'h00};   // GAIN
            8'd57: entry = {8'h10, 8'h00};   // AECH
            8'd58: entry = {8'h0D, 8'h40};   // COM4
            8'd59: entry = {8'h14, 8'h18};   // COM9
            8'd60: entry = {8'hA5, 8'h05};   // BD50MAX
            8'd61: entry = {8'hAB, 8'h07};   // BD60MAX
            8'd62: entry = {8'h24, 8'h95};   // AEW
            8'd63: entry = {8'h25, 8'h33};   // AEB
            8'd64: entry = {8'h26, 8'hE3};   // VPT
            8'd65: entry = {8'h9F, 8'h78};   // HAECC1..7
            8'd66: entry = {8'hA0, 8'h68};
            8'd67: entry = {8'hA1, 8'h03};
            8'd68: entry = {8'hA6, 8'hD8};
            8'd69: entry = {8'hA7, 8'hD8};
            8'd70: entry = {8'hA8, 8'hF0};
            8'd71: entry = {8'hA9, 8'h90};
            8'd72: entry = {8'hAA, 8'h94};
            8'd73: entry = {8'h13, 8'hE5};   // COM8, AGC/AEC back on
            8'd74: entry = {8'h15, 8'h00};   // COM10
            8'd75: entry = {8'h6B, 8'h0A};   // DBLV
            default: entry = {DELAY_MARK, 8'h00};
        endcase
    end

endmodule

// File: rtl/ov7670_cfg_ctrl.sv
// OV7670 power-up configuration sequencer. Waits out sensor power-up, then
// walks the register table issuing one SCCB write per entry with timeout and
// retry, and reports busy/done/error status.
//   sclk, rst          : clock, asynchronous active-high reset
//   start              : re-run pulse, honoured only when done
//   wr_req/addr/data   : write request to the SCCB master
//   wr_done            : completion pulse from the SCCB master
//   cfg_busy/done/err  : status; cfg_err sticky until reset or start
//   err_cnt            : entries skipped after exhausting retries (saturating)
//   reg_idx            : index of the current entry
module ov7670_cfg_ctrl
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES   = 200000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned DELAY_CYCLES   = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned REG_NUM        = OV7670_REG_NUM
)(
    input  logic       sclk,
    input  logic       rst,
    input  logic       start,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] err_cnt,
    output logic [7:0] reg_idx
);

    localparam int unsigned MAX_PG  = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_DT  = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_MAX = (MAX_PG > MAX_DT) ? MAX_PG : MAX_DT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    cfg_state_e       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [RTY_W-1:0] retry, retry_nxt;
    logic             pend, pend_nxt;
    logic [7:0]       idx_nxt, addr_nxt, data_nxt, err_cnt_nxt;
    logic             err_nxt, req_nxt, busy_nxt, done_nxt;
    cfg_entry_t       rom_entry;

    ov7670_cfg_rom u_rom (
        .idx   (reg_idx),
        .entry (rom_entry)
    );

    // State and registered outputs.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= ST_PWRUP;
            tmr      <= '0;
            retry    <= '0;
            pend     <= 1'b0;
            reg_idx  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_req   <= 1'b0;
            cfg_busy <= 1'b1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            retry    <= retry_nxt;
            pend     <= pend_nxt;
            reg_idx  <= idx_nxt;
            wr_addr  <= addr_nxt;
            wr_data  <= data_nxt;
            wr_req   <= req_nxt;
            cfg_busy <= busy_nxt;
            cfg_done <= done_nxt;
            cfg_err  <= err_nxt;
            err_cnt  <= err_cnt_nxt;
        end
    end

    // Next state. tmr counts cycles spent in the current timed state and is
    // cleared on every transition, so each wait lasts exactly its parameter.
    always_comb begin
        state_nxt   = state;
        tmr_nxt     = '0;
        retry_nxt   = retry;
        pend_nxt    = pend;
        idx_nxt     = reg_idx;
        addr_nxt    = wr_addr;
        data_nxt    = wr_data;
        err_nxt     = cfg_err;
        err_cnt_nxt = err_cnt;

        unique case (state)
            ST_PWRUP: begin
                if (tmr == TMR_W'(PWRUP_CYCLES - 1)) state_nxt = ST_LOAD;
                else                                 tmr_nxt   = tmr + TMR_W'(1);
            end
            ST_LOAD: begin
                addr_nxt  = rom_entry.addr;
                data_nxt  = rom_entry.data;
                retry_nxt = '0;
                pend_nxt  = 1'b0;
                state_nxt = is_delay_mark(rom_entry) ? ST_DELAY : ST_REQ;
            end
            ST_REQ: begin
                // wr_done has priority over a coincident timeout.
                if (wr_done) begin
                    pend_nxt  = 1'b0;
                    state_nxt = ST_GAP;
                end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ST_GAP;
                    if (retry < RTY_W'(MAX_RETRY)) begin
                        retry_nxt = retry + RTY_W'(1);
                        pend_nxt  = 1'b1;
                    end else begin
                        pend_nxt = 1'b0;
                        err_nxt  = 1'b1;
                        if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
                    end
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_DELAY: begin
                if (tmr == TMR_W'(DELAY_CYCLES - 1)) state_nxt = ST_NEXT;
                else                                 tmr_nxt   = tmr + TMR_W'(1);
            end
            ST_GAP: begin
                if (tmr == TMR_W'(GAP_CYCLES - 1)) state_nxt = pend ? ST_REQ : ST_NEXT;
                else                               tmr_nxt   = tmr + TMR_W'(1);
            end
            ST_NEXT: begin
                if (reg_idx == 8'(REG_NUM - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = reg_idx + 8'd1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    idx_nxt     = '0;
                    err_nxt     = 1'b0;
                    err_cnt_nxt = '0;
                    state_nxt   = ST_LOAD;
                end
            end
            default: state_nxt = ST_PWRUP;
        endcase

        // Status outputs follow the state being entered so they register with it.
        req_nxt  = (state_nxt == ST_REQ);
        busy_nxt = (state_nxt != ST_DONE);
        done_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_ov7670_cfg_ctrl.sv
// Self-checking bench for ov7670_cfg_ctrl with shrunk timing parameters.
// A transaction-level model tracks table position, attempts and skipped
// entries, and predicts request/idle lengths from the sequencing rules.
module tb_ov7670_cfg_ctrl;

    localparam int P  = 40;   // power-up
    localparam int G  = 4;    // gap
    localparam int D  = 30;   // delay marker
    localparam int T  = 20;   // timeout
    localparam int MR = 2;    // retries
    localparam int N  = 8;    // table length

    logic       sclk = 1'b0;
    logic       rst, start, wr_done;
    logic       wr_req, cfg_busy, cfg_done, cfg_err;
    logic [7:0] wr_addr, wr_data, err_cnt, reg_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sclk = ~sclk;

    ov7670_cfg_ctrl #(
        .PWRUP_CYCLES   (P),
        .GAP_CYCLES     (G),
        .DELAY_CYCLES   (D),
        .TIMEOUT_CYCLES (T),
        .MAX_RETRY      (MR),
        .REG_NUM        (N)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .start    (start),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_cnt  (err_cnt),
        .reg_idx  (reg_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected {addr, data} for the first N table entries.
    function automatic logic [15:0] tbl(input int i);
        case (i)
            0: return 16'h1280;
            1: return 16'hFF00;
            2: return 16'h1204;
            3: return 16'h1180;
            4: return 16'h0C00;
            5: return 16'h3E00;
            6: return 16'h0400;
            7: return 16'h40D0;
            default: return 16'hFF00;
        endcase
    endfunction

    // Count cycles (current one is 1) until wr_req is seen high.
    task automatic wait_req(output int cyc);
        cyc = 1;
        while (!wr_req && cyc < 1000) begin
            @(posedge sclk); #1;
            cyc++;
        end
    endtask

    // Pulse start in DONE and check the status it produces.
    task automatic do_start();
        int cyc;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        chk("start_busy", cfg_busy, 1);
        chk("start_done", cfg_done, 0);
        chk("start_idx", reg_idx, 0);
        chk("start_err", cfg_err, 0);
        chk("start_errcnt", err_cnt, 0);
        wait_req(cyc);
        chk("start_req_lat", cyc, 2);
    endtask

    // Called in the first cycle of the first request. never_ack: responder
    // never returns wr_done. inj_start: pulse start inside a later request.
    task automatic run_table(input bit never_ack, input bit inj_start);
        int i, a, errs, k, len, low, exp_low, j;
        bit adv, exp_done, inj;
        i = 0; a = 0; errs = 0;
        forever begin
            chk("addr", wr_addr, tbl(i) >> 8);
            chk("data", wr_data, tbl(i) & 16'hFF);

            if (never_ack) k = 0;
            else begin
                case ($urandom_range(0, 7))
                    0, 1:    k = 0;      // no answer: timeout
                    2:       k = T;      // answer on the timeout cycle
                    default: k = int'($urandom_range(1, T - 1));
                endcase
            end
            inj = inj_start && (i == 3) && (a == 0);

            len = 1;
            forever begin
                wr_done = (k == len);
                if (inj && len == 1) start = 1'b1;
                @(posedge sclk); #1;
                wr_done = 1'b0;
                start   = 1'b0;
                if (!wr_req || len >= T + 5) break;
                len++;
            end
            chk("req_len", len, (k != 0) ? k : T);
            if (inj) begin
                chk("start_ign_idx", reg_idx, i);
                chk("start_ign_busy", cfg_busy, 1);
            end

            // Model: outcome of this attempt.
            if (k != 0) begin a = 0; adv = 1; end
            else if (a < MR) begin a++; adv = 0; end
            else begin errs++; a = 0; adv = 1; end

            // Model: idle cycles before the next request, or before done.
            exp_done = 0;
            if (!adv) exp_low = G;
            else begin
                exp_low = G + 1;
                j = i;
                forever begin
                    if (j == N - 1) begin exp_done = 1; break; end
                    j++;
                    exp_low += 1;
                    if ((tbl(j) >> 8) == 16'hFF) exp_low += D + 1;
                    else break;
                end
                i = j;
            end

            // Stray wr_done pulses outside a request must be ignored.
            low = 1;
            forever begin
                wr_done = ($urandom_range(0, 3) == 0);
                @(posedge sclk); #1;
                wr_done = 1'b0;
                if (wr_req || cfg_done || low >= 400) break;
                low++;
            end
            chk("gap_len", low, exp_low);
            chk("done_flag", cfg_done, exp_done);
            if (cfg_done || !wr_req) break;
        end
        chk("end_errcnt", err_cnt, errs);
        chk("end_err", cfg_err, (errs > 0) ? 1 : 0);
        chk("end_busy", cfg_busy, 0);
        chk("end_idx", reg_idx, N - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; wr_done = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_req", wr_req, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", cfg_busy, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_idx", reg_idx, 0);
        rst = 1'b0;

        // First request lands in cycle P+2 after release.
        wait_req(cyc);
        chk("pwrup_lat", cyc, P + 2);
        run_table(1'b0, 1'b1);

        // Re-run with a silent SCCB master: every real entry is skipped.
        do_start();
        run_table(1'b1, 1'b0);
        chk("never_errcnt", err_cnt, 7);

        // Reset in the middle of a request.
        do_start();
        repeat (3) @(posedge sclk);
        #3 rst = 1'b1;
        #1;
        chk("arst_req", wr_req, 0);
        chk("arst_busy", cfg_busy, 1);
        chk("arst_idx", reg_idx, 0);
        chk("arst_addr", wr_addr, 0);
        @(posedge sclk);
        @(posedge sclk); #1;
        rst = 1'b0;
        wait_req(cyc);
        chk("pwrup_lat2", cyc, P + 2);
        run_table(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
